// File: rtl/vga_bitmap_scroller.sv
// VGA timing generator that paints a tiled, horizontally scrolling 1-bit bitmap.
// Bitmap rows are only rewritten during vertical blanking, so a visible frame never tears.
module vga_bitmap_scroller #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int CLK_DIV    = 2,
  parameter int COLS       = 128,
  parameter int ROWS       = 16,
  parameter int SCALE_LOG2 = 0
) (
  input  logic                    clk,
  input  logic                    Reset,
  input  logic                    scroll_en,
  input  logic [3:0]              scroll_step,
  input  logic [11:0]             fg_color,
  input  logic [11:0]             bg_color,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [$clog2(ROWS)-1:0] wr_row,
  input  logic [COLS-1:0]         wr_data,
  output logic [3:0]              RED,
  output logic [3:0]              GREEN,
  output logic [3:0]              BLUE,
  output logic                    vga_h_sync,
  output logic                    vga_v_sync,
  output logic                    inDisplayArea,
  output logic                    frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int X_W     = $clog2(H_TOTAL);
  localparam int Y_W     = $clog2(V_TOTAL);
  localparam int COL_W   = $clog2(COLS);
  localparam int ROW_W   = $clog2(ROWS);
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [31:0] X_LAST = 32'(H_TOTAL - 1);
  localparam logic [31:0] Y_LAST = 32'(V_TOTAL - 1);
  localparam logic [31:0] X_ACT  = 32'(H_ACTIVE);
  localparam logic [31:0] Y_ACT  = 32'(V_ACTIVE);
  localparam logic [31:0] HS_BEG = 32'(H_ACTIVE + H_FP);
  localparam logic [31:0] HS_END = 32'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [31:0] VS_BEG = 32'(V_ACTIVE + V_FP);
  localparam logic [31:0] VS_END = 32'(V_ACTIVE + V_FP + V_SYNC);

  logic [DIV_W-1:0] div_cnt;
  logic             pix_en;
  logic [X_W-1:0]   CounterX;
  logic [Y_W-1:0]   CounterY;
  logic [31:0]      x32;
  logic [31:0]      y32;
  logic             last_x;
  logic             last_y;
  logic             frame_end;
  logic             h_sync_raw;
  logic             v_sync_raw;
  logic             active_raw;
  logic [COL_W-1:0] scroll_off;
  logic [COL_W-1:0] col_idx;
  logic [ROW_W-1:0] row_idx;
  logic [COLS-1:0]  bitmap [ROWS];
  logic             pix_bit;

  assign pix_en = (div_cnt == DIV_W'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (Reset)       div_cnt <= '0;
    else if (pix_en) div_cnt <= '0;
    else             div_cnt <= div_cnt + 1'b1;
  end

  assign x32       = 32'(CounterX);
  assign y32       = 32'(CounterY);
  assign last_x    = (x32 == X_LAST);
  assign last_y    = (y32 == Y_LAST);
  assign frame_end = pix_en && last_x && last_y;

  always_ff @(posedge clk) begin
    if (Reset) begin
      CounterX <= '0;
      CounterY <= '0;
    end else if (pix_en) begin
      if (last_x) begin
        CounterX <= '0;
        CounterY <= last_y ? '0 : CounterY + 1'b1;
      end else begin
        CounterX <= CounterX + 1'b1;
      end
    end
  end

  assign h_sync_raw = !((x32 >= HS_BEG) && (x32 < HS_END));
  assign v_sync_raw = !((y32 >= VS_BEG) && (y32 < VS_END));
  assign active_raw = (x32 < X_ACT) && (y32 < Y_ACT);

  // Truncating the scaled coordinates to the bitmap index width gives the tiling wrap.
  assign col_idx  = COL_W'(x32 >> SCALE_LOG2) + scroll_off;
  assign row_idx  = ROW_W'(y32 >> SCALE_LOG2);
  assign pix_bit  = bitmap[row_idx][col_idx];
  assign wr_ready = (y32 >= Y_ACT);

  always_ff @(posedge clk) begin
    if (Reset) begin
      {RED, GREEN, BLUE} <= 12'h000;
      vga_h_sync         <= 1'b1;
      vga_v_sync         <= 1'b1;
      inDisplayArea      <= 1'b0;
    end else if (pix_en) begin
      {RED, GREEN, BLUE} <= active_raw ? (pix_bit ? fg_color : bg_color) : 12'h000;
      vga_h_sync         <= h_sync_raw;
      vga_v_sync         <= v_sync_raw;
      inDisplayArea      <= active_raw;
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      frame_start <= 1'b0;
      scroll_off  <= '0;
    end else begin
      frame_start <= frame_end;
      if (frame_end && scroll_en) scroll_off <= scroll_off + COL_W'(scroll_step);
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      for (int r = 0; r < ROWS; r++) bitmap[r] <= '0;
    end else if (wr_valid && wr_ready) begin
      bitmap[wr_row] <= wr_data;
    end
  end

endmodule

// File: tb/tb_vga_bitmap_scroller.sv
// Bench for vga_bitmap_scroller: a shrunken-timing instance checked every cycle against a
// pixel-index model, plus a SCALE_LOG2=1 / CLK_DIV=1 instance for the scaling corner case.
module tb_vga_bitmap_scroller;

  localparam int AH = 132, AHFP = 2, AHS = 4, AHBP = 2;
  localparam int AV = 2, AVFP = 1, AVS = 2, AVBP = 1;
  localparam int ADIV = 2;
  localparam int AHT = AH + AHFP + AHS + AHBP;
  localparam int AVT = AV + AVFP + AVS + AVBP;
  localparam int AFR = AHT * AVT;
  localparam int BHT = 11, BFR = 77;

  typedef struct {
    int          x;
    int          y;
    logic [11:0] rgb;
  } pix_vec_t;

  logic         clk = 1'b0;
  logic         Reset = 1'b1;
  logic         scroll_en, wr_valid, wr_ready;
  logic [3:0]   scroll_step, wr_row;
  logic [11:0]  fg_color, bg_color;
  logic [127:0] wr_data;
  logic [3:0]   RED, GREEN, BLUE;
  logic         vga_h_sync, vga_v_sync, inDisplayArea, frame_start;

  logic         b_scroll_en = 1'b0;
  logic [3:0]   b_scroll_step = 4'd0;
  logic         b_wr_valid = 1'b0, b_wr_ready;
  logic [3:0]   b_wr_row = 4'd0;
  logic [127:0] b_wr_data = '0;
  logic [3:0]   b_red, b_green, b_blue;
  logic         b_hs, b_vs, b_de, b_fs;

  int tests = 0;
  int failures = 0;
  int mon_fail = 0;
  bit mon_en = 1'b0;

  int           cyc = 0;
  int           m_off = 0;
  logic [127:0] m_bitmap [16];
  logic [11:0]  exp_rgb;
  logic         exp_hs, exp_vs, exp_de, exp_fs, exp_ready;

  pix_vec_t     a_tab [6];
  pix_vec_t     b_tab [8];
  int           hs_low, vs_low, fs_cnt, fs_first, fs_second, seen, base;
  logic [127:0] pat;

  always #5 clk = ~clk;

  vga_bitmap_scroller #(
    .H_ACTIVE(AH), .H_FP(AHFP), .H_SYNC(AHS), .H_BP(AHBP),
    .V_ACTIVE(AV), .V_FP(AVFP), .V_SYNC(AVS), .V_BP(AVBP),
    .CLK_DIV(ADIV), .COLS(128), .ROWS(16), .SCALE_LOG2(0)
  ) dut (
    .clk(clk), .Reset(Reset), .scroll_en(scroll_en), .scroll_step(scroll_step),
    .fg_color(fg_color), .bg_color(bg_color), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_row(wr_row), .wr_data(wr_data), .RED(RED), .GREEN(GREEN), .BLUE(BLUE),
    .vga_h_sync(vga_h_sync), .vga_v_sync(vga_v_sync), .inDisplayArea(inDisplayArea),
    .frame_start(frame_start)
  );

  vga_bitmap_scroller #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .CLK_DIV(1), .COLS(128), .ROWS(16), .SCALE_LOG2(1)
  ) dut_b (
    .clk(clk), .Reset(Reset), .scroll_en(b_scroll_en), .scroll_step(b_scroll_step),
    .fg_color(fg_color), .bg_color(bg_color), .wr_valid(b_wr_valid), .wr_ready(b_wr_ready),
    .wr_row(b_wr_row), .wr_data(b_wr_data), .RED(b_red), .GREEN(b_green), .BLUE(b_blue),
    .vga_h_sync(b_hs), .vga_v_sync(b_vs), .inDisplayArea(b_de), .frame_start(b_fs)
  );

  // Reference model works on the absolute pixel index q since reset release, not on counters.
  function automatic bit a_ready(input int n);
    return ((n / ADIV) / AHT) % AVT >= AV;
  endfunction

  function automatic bit a_hs(input int q);
    return !((q % AHT) >= AH + AHFP && (q % AHT) < AH + AHFP + AHS);
  endfunction

  function automatic bit a_vs(input int q);
    return !(((q / AHT) % AVT) >= AV + AVFP && ((q / AHT) % AVT) < AV + AVFP + AVS);
  endfunction

  function automatic bit a_de(input int q);
    return (q % AHT) < AH && ((q / AHT) % AVT) < AV;
  endfunction

  function automatic logic [11:0] a_rgb(input int q);
    if (!a_de(q)) return 12'h000;
    return m_bitmap[((q / AHT) % AVT) % 16][((q % AHT) + m_off) % 128] ? fg_color : bg_color;
  endfunction

  always @(posedge clk) begin
    if (Reset) begin
      cyc       <= 0;
      m_off     <= 0;
      for (int r = 0; r < 16; r++) m_bitmap[r] <= '0;
      exp_rgb   <= 12'h000;
      exp_hs    <= 1'b1;
      exp_vs    <= 1'b1;
      exp_de    <= 1'b0;
      exp_fs    <= 1'b0;
      exp_ready <= 1'b0;
    end else begin
      cyc <= cyc + 1;
      if (wr_valid && a_ready(cyc)) m_bitmap[wr_row] <= wr_data;
      exp_ready <= a_ready(cyc + 1);
      exp_fs    <= ((cyc + 1) % (ADIV * AFR)) == 0;
      if (((cyc + 1) % ADIV) == 0) begin
        exp_rgb <= a_rgb((cyc + 1) / ADIV - 1);
        exp_hs  <= a_hs((cyc + 1) / ADIV - 1);
        exp_vs  <= a_vs((cyc + 1) / ADIV - 1);
        exp_de  <= a_de((cyc + 1) / ADIV - 1);
        if ((((cyc + 1) / ADIV) % AFR) == 0 && scroll_en)
          m_off <= (m_off + int'(scroll_step)) % 128;
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en && mon_fail < 10) begin
      tests++;
      if ({RED, GREEN, BLUE, vga_h_sync, vga_v_sync, inDisplayArea, frame_start, wr_ready} !==
          {exp_rgb, exp_hs, exp_vs, exp_de, exp_fs, exp_ready}) begin
        failures++;
        mon_fail++;
        $display("[TB] FAIL monitor cyc=%0d got rgb=%h hs=%b vs=%b de=%b fs=%b rdy=%b want rgb=%h hs=%b vs=%b de=%b fs=%b rdy=%b",
                 cyc, {RED, GREEN, BLUE}, vga_h_sync, vga_v_sync, inDisplayArea, frame_start, wr_ready,
                 exp_rgb, exp_hs, exp_vs, exp_de, exp_fs, exp_ready);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic [3:0] step,
                               input logic [11:0] fg, input logic [11:0] bg);
    scroll_en   = en;
    scroll_step = step;
    fg_color    = fg;
    bg_color    = bg;
  endtask

  task automatic waitCyc(input int target);
    if (target < cyc || target - cyc > 20000) begin
      tests++;
      failures++;
      $display("[TB] FAIL wait_bound: at cyc %0d, target %0d", cyc, target);
    end else begin
      while (cyc < target) @(negedge clk);
    end
  endtask

  task automatic waitPixelA(input int p);
    waitCyc((p + 1) * ADIV);
  endtask

  function automatic int nextFrameA();
    return ((cyc / ADIV) / AFR + 1) * AFR;
  endfunction

  task automatic waitBlankA();
    int tgt;
    tgt = ((cyc / ADIV) / AFR) * AFR + AV * AHT;
    if (cyc / ADIV >= tgt) tgt += AFR;
    waitCyc(tgt * ADIV);
  endtask

  task automatic writeRowA(input logic [3:0] r, input logic [127:0] d);
    wr_valid = 1'b1;
    wr_row   = r;
    wr_data  = d;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  initial begin
    a_tab[0] = '{x: 0,   y: 0, rgb: 12'h00F};
    a_tab[1] = '{x: 0,   y: 1, rgb: 12'hF00};
    a_tab[2] = '{x: 1,   y: 1, rgb: 12'h00F};
    a_tab[3] = '{x: 128, y: 1, rgb: 12'hF00};
    a_tab[4] = '{x: 129, y: 1, rgb: 12'h00F};
    a_tab[5] = '{x: 132, y: 1, rgb: 12'h000};
    b_tab[0] = '{x: 0, y: 0, rgb: 12'hF00};
    b_tab[1] = '{x: 1, y: 0, rgb: 12'hF00};
    b_tab[2] = '{x: 2, y: 0, rgb: 12'h00F};
    b_tab[3] = '{x: 8, y: 0, rgb: 12'h000};
    b_tab[4] = '{x: 0, y: 1, rgb: 12'hF00};
    b_tab[5] = '{x: 1, y: 1, rgb: 12'hF00};
    b_tab[6] = '{x: 3, y: 1, rgb: 12'h00F};
    b_tab[7] = '{x: 0, y: 2, rgb: 12'h00F};

    wr_valid = 1'b0;
    wr_row   = 4'd0;
    wr_data  = '0;
    applyStimulus(1'b0, 4'd0, 12'hF00, 12'h00F);
    repeat (3) @(negedge clk);
    checkOutput("reset_rgb", {RED, GREEN, BLUE}, 0);
    checkOutput("reset_hsync", vga_h_sync, 1);
    checkOutput("reset_vsync", vga_v_sync, 1);
    checkOutput("reset_de", inDisplayArea, 0);
    checkOutput("reset_fs", frame_start, 0);
    checkOutput("reset_ready", wr_ready, 0);
    mon_en = 1'b1;
    Reset  = 1'b0;

    // Two full frames of sync timing measured from release.
    hs_low = 0; vs_low = 0; fs_cnt = 0; fs_first = -1; fs_second = -1;
    for (int i = 0; i < 2 * ADIV * AFR; i++) begin
      @(negedge clk);
      if (!vga_h_sync) hs_low++;
      if (!vga_v_sync) vs_low++;
      if (frame_start) begin
        fs_cnt++;
        if (fs_cnt == 1) fs_first = cyc;
        else fs_second = cyc;
      end
    end
    checkOutput("hsync_low_clks", hs_low, 2 * AVT * AHS * ADIV);
    checkOutput("vsync_low_clks", vs_low, 2 * AVS * AHT * ADIV);
    checkOutput("frame_start_count", fs_cnt, 2);
    checkOutput("frame_start_first", fs_first, AFR * ADIV);
    checkOutput("frame_start_period", fs_second - fs_first, AFR * ADIV);

    // Scaled instance: one bitmap bit covers a 2x2 pixel block.
    waitCyc((cyc / BFR + 1) * BFR + 4 * BHT);
    checkOutput("b_ready_blank", b_wr_ready, 1);
    b_wr_valid = 1'b1;
    b_wr_row   = 4'd0;
    b_wr_data  = 128'h1;
    @(negedge clk);
    b_wr_valid = 1'b0;
    base = (cyc / BFR + 1) * BFR;
    for (int i = 0; i < 8; i++) begin
      waitCyc(base + b_tab[i].y * BHT + b_tab[i].x + 1);
      checkOutput($sformatf("scale(%0d,%0d)", b_tab[i].x, b_tab[i].y), {b_red, b_green, b_blue}, b_tab[i].rgb);
    end

    // Pixel mapping and column wrap.
    waitBlankA();
    checkOutput("a_ready_blank", wr_ready, 1);
    writeRowA(4'd1, 128'h1);
    base = nextFrameA();
    for (int i = 0; i < 6; i++) begin
      waitPixelA(base + a_tab[i].y * AHT + a_tab[i].x);
      checkOutput($sformatf("pixmap(%0d,%0d)", a_tab[i].x, a_tab[i].y), {RED, GREEN, BLUE}, a_tab[i].rgb);
    end

    // A write requested during active video waits for the first blanking cycle.
    base = nextFrameA();
    waitPixelA(base + 10);
    checkOutput("gate_ready_low", wr_ready, 0);
    pat = {$urandom, $urandom, $urandom, $urandom};
    wr_valid = 1'b1;
    wr_row   = 4'd0;
    wr_data  = pat;
    seen = -1;
    for (int g = 0; g < 4000; g++) begin
      @(negedge clk);
      if (wr_ready) begin
        seen = cyc;
        break;
      end
    end
    checkOutput("gate_accept_cyc", seen, (base + AV * AHT) * ADIV);
    @(negedge clk);
    wr_valid = 1'b0;
    base = nextFrameA();
    for (int x = 0; x < 80; x += 37) begin
      waitPixelA(base + x);
      checkOutput($sformatf("gate_pix%0d", x), {RED, GREEN, BLUE}, pat[x] ? 12'hF00 : 12'h00F);
    end

    // Scroll by 4 columns per frame for 32 frames, wrapping back to offset 0.
    waitBlankA();
    pat = {$urandom, $urandom, $urandom, $urandom};
    writeRowA(4'd0, pat);
    applyStimulus(1'b1, 4'd4, 12'hF00, 12'h00F);
    base = nextFrameA();
    for (int k = 1; k <= 32; k++) begin
      waitPixelA(base + (k - 1) * AFR);
      checkOutput($sformatf("scroll_f%0d", k), {RED, GREEN, BLUE}, pat[(4 * k) % 128] ? 12'hF00 : 12'h00F);
    end
    applyStimulus(1'b0, 4'd0, 12'hF00, 12'h00F);

    // Random writes, scroll controls and colours, judged by the model.
    for (int i = 0; i < 2 * ADIV * AFR; i++) begin
      @(negedge clk);
      wr_valid = 1'($urandom_range(1));
      wr_row   = 4'($urandom_range(15));
      wr_data  = {$urandom, $urandom, $urandom, $urandom};
      applyStimulus(($urandom_range(3) == 0), 4'($urandom_range(15)),
                    12'($urandom), 12'($urandom));
    end
    wr_valid = 1'b0;
    applyStimulus(1'b0, 4'd0, 12'hF00, 12'h00F);

    // Mid-frame reset clears everything and restarts the frame.
    waitBlankA();
    writeRowA(4'd0, '1);
    base = nextFrameA();
    waitPixelA(base + AHT + 50);
    Reset = 1'b1;
    @(negedge clk);
    checkOutput("midrst_rgb", {RED, GREEN, BLUE}, 0);
    checkOutput("midrst_hsync", vga_h_sync, 1);
    checkOutput("midrst_vsync", vga_v_sync, 1);
    checkOutput("midrst_de", inDisplayArea, 0);
    checkOutput("midrst_fs", frame_start, 0);
    checkOutput("midrst_ready", wr_ready, 0);
    @(negedge clk);
    Reset = 1'b0;
    fs_cnt = 0;
    while (cyc < AFR * ADIV) begin
      @(negedge clk);
      if (cyc < AFR * ADIV && frame_start) fs_cnt++;
      if (cyc == ADIV) checkOutput("midrst_bitmap_clear", {RED, GREEN, BLUE}, 12'h00F);
    end
    checkOutput("midrst_no_early_fs", fs_cnt, 0);
    checkOutput("midrst_fs_after_frame", frame_start, 1);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/vga_bitmap_scroller.md
VGA_BITMAP_SCROLLER -- requirements
Module: vga_bitmap_scroller

Interface
REQ-001 Parameters SHALL be, as name, default, meaning:
- H_ACTIVE 640: visible pixels per line.
- H_FP 16, H_SYNC 96, H_BP 48: horizontal front porch, sync and back porch, in pixels.
- V_ACTIVE 480: visible lines.
- V_FP 10, V_SYNC 2, V_BP 33: vertical front porch, sync and back porch, in lines.
- CLK_DIV 2: clk cycles per pixel, at least 1.
- COLS 128, ROWS 16: bitmap size in bits; both powers of two.
- SCALE_LOG2 0: each bitmap bit covers 2^SCALE_LOG2 x 2^SCALE_LOG2 pixels.
REQ-002 Ports SHALL be, as name, direction, width, meaning:
- clk, in, 1: single clock; the only clock.
- Reset, in, 1: synchronous, active-high reset.
- scroll_en, in, 1: enables horizontal scrolling.
- scroll_step, in, 4: columns advanced per frame.
- fg_color, in, 12: {R,G,B} colour for bitmap bits = 1.
- bg_color, in, 12: {R,G,B} colour for bitmap bits = 0.
- wr_valid, in, 1: row-write request.
- wr_ready, out, 1: write accepted this cycle.
- wr_row, in, log2(ROWS): row to write.
- wr_data, in, COLS: row contents; bit c is column c.
- RED, GREEN, BLUE, out, 4 each: pixel colour.
- vga_h_sync, vga_v_sync, out, 1 each: active-low syncs.
- inDisplayArea, out, 1: visible pixel; aligned with RGB.
- frame_start, out, 1: one-cycle pulse.

Function
REQ-003 A pixel-enable divider SHALL assert pix_en once every CLK_DIV clk cycles; the first assertion SHALL be the CLK_DIV-th cycle after Reset is released.
REQ-004 CounterX and CounterY SHALL advance only on pix_en.
- CounterX counts 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP.
- CounterX SHALL wrap to 0, and CounterY SHALL then increment.
- CounterY counts 0..V_TOTAL-1 and wraps to 0 after the last line.
REQ-005 Raw sync timing:
- h_sync_raw SHALL be low for CounterX in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1].
- v_sync_raw SHALL be low for CounterY in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1].
- active_raw = (CounterX < H_ACTIVE) && (CounterY < V_ACTIVE).
REQ-006 Bitmap lookup SHALL use:
- col = ((CounterX >> SCALE_LOG2) + scroll_off) mod COLS.
- row = (CounterY >> SCALE_LOG2) mod ROWS.
- The bitmap wraps as tiles in both axes.
REQ-007 Output register stage (one pipeline stage; registered on pix_en):
- vga_h_sync, vga_v_sync and inDisplayArea SHALL be the raw values delayed one pixel.
- RGB SHALL be fg_color if bitmap[row][col] = 1, else bg_color, when active_raw; otherwise 0.
- fg_color/bg_color SHALL be sampled in the same cycle as the bitmap bit.
REQ-008 Scroll offset:
- scroll_off SHALL be log2(COLS) bits wide.
- It SHALL update only in the cycle where pix_en && CounterX = H_TOTAL-1 && CounterY = V_TOTAL-1.
- Update: scroll_off <= (scroll_off + scroll_step) mod COLS if scroll_en; hold otherwise.
REQ-009 frame_start SHALL pulse for exactly one clk cycle, the cycle after the scroll_off update point, whatever the value of scroll_en.
REQ-010 wr_ready SHALL be 1 exactly while CounterY >= V_ACTIVE (vertical blanking), so the active region never tears.
REQ-011 Row writes:
- A write occurs when wr_valid && wr_ready.
- bitmap[wr_row] <= wr_data, visible from the next clk cycle.
- One row per cycle; back-to-back writes are allowed.
- wr_valid while wr_ready = 0 SHALL have no effect; the requester holds it.
REQ-012 If a write coincides with the scroll_off update, both SHALL take effect in that cycle.

Reset
REQ-013 While Reset = 1 at a clk edge, all of the following SHALL be cleared:
- CounterX, CounterY, the divider and scroll_off SHALL be 0.
- Every bitmap bit SHALL be 0.
- RED, GREEN and BLUE SHALL be 0.
- vga_h_sync and vga_v_sync SHALL be 1.
- inDisplayArea, frame_start and wr_ready SHALL be 0.
REQ-014 Reset asserted mid-line or mid-frame SHALL abort the frame, with no frame_start pulse; timing SHALL restart at CounterX = CounterY = 0 on release.

Verification
REQ-015 The bench SHALL cover these directed scenarios, at default parameters unless stated:
- Sync timing: reset, run 2 frames -> vga_h_sync low for 192 clk every 1600 clk; vga_v_sync low for 2 lines (3200 clk) every 525 lines; frame_start every 840000 clk.
- Pixel mapping: in blanking write row 1 = bit 0 set only, fg=12'hF00, bg=12'h00F -> at pixel (0,1), RED=F and BLUE=0; at (1,1), RED=0 and BLUE=F; at (128,1) same as (0,1) (column wrap).
- Write gating: wr_valid during active video -> wr_ready=0, bitmap unchanged; held until CounterY=480 -> accepted in the first blanking cycle.
- Scroll wrap: scroll_en=1, scroll_step=4, 32 frames -> scroll_off 4,8,...,124,0; pixel x=0 shows column (4*frames) mod 128.
- Mid-frame reset: Reset asserted at CounterY=200 -> all outputs at reset values next cycle; bitmap cleared; no frame_start until a full new frame completes.
- SCALE_LOG2=1, CLK_DIV=1: bitmap bit (row 0, col 0) = 1 -> pixels (0,0), (1,0), (0,1), (1,1) show fg; (2,0) shows bg.
